// File: rtl/vpu_issue_ctrl.sv
// Non-pipelined VPU issue controller: latch a decoded instruction, read operands,
// run the execution unit under a watchdog, write back and return a tagged response.

package VPU_PKG;
  localparam int unsigned STREAM_ID_WIDTH = 4;
  localparam int unsigned OP_FUNC_WIDTH   = 6;
  localparam int unsigned RF_ADDR_WIDTH   = 8;

  typedef struct packed {
    logic [OP_FUNC_WIDTH-1:0] op_func;
  } vpu_exec_req_t;

  typedef struct packed {
    logic [OP_FUNC_WIDTH-1:0] op_func;
    logic [2:0]               rvalid;
    logic [RF_ADDR_WIDTH-1:0] raddr0;
    logic [RF_ADDR_WIDTH-1:0] raddr1;
    logic [RF_ADDR_WIDTH-1:0] raddr2;
    logic [RF_ADDR_WIDTH-1:0] waddr;
  } vpu_instr_decoded_t;
endpackage

module vpu_issue_ctrl #(
  parameter int unsigned DATA_WIDTH   = 512,
  parameter int unsigned ADDR_WIDTH   = 8,
  parameter int unsigned RD_LAT       = 2,
  parameter int unsigned EXEC_TIMEOUT = 1023
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          ctrl_valid_i,
  output logic                                          ctrl_ready_o,
  input  logic [$bits(VPU_PKG::vpu_instr_decoded_t)-1:0] instr_decoded_i,
  input  logic [VPU_PKG::STREAM_ID_WIDTH-1:0]           stream_id_i,
  output logic [2:0]                                    rd_en_o,
  output logic [ADDR_WIDTH-1:0]                         rd_addr0_o,
  output logic [ADDR_WIDTH-1:0]                         rd_addr1_o,
  output logic [ADDR_WIDTH-1:0]                         rd_addr2_o,
  input  logic [DATA_WIDTH-1:0]                         rd_data0_i,
  input  logic [DATA_WIDTH-1:0]                         rd_data1_i,
  input  logic [DATA_WIDTH-1:0]                         rd_data2_i,
  output logic                                          exec_valid_o,
  input  logic                                          exec_ready_i,
  output logic [$bits(VPU_PKG::vpu_exec_req_t)-1:0]     exec_op_o,
  output logic [DATA_WIDTH-1:0]                         exec_src0_o,
  output logic [DATA_WIDTH-1:0]                         exec_src1_o,
  output logic [DATA_WIDTH-1:0]                         exec_src2_o,
  input  logic                                          exec_done_i,
  input  logic [DATA_WIDTH-1:0]                         exec_result_i,
  output logic                                          wr_en_o,
  output logic [ADDR_WIDTH-1:0]                         wr_addr_o,
  output logic [DATA_WIDTH-1:0]                         wr_data_o,
  output logic                                          resp_valid_o,
  input  logic                                          resp_ready_i,
  output logic [VPU_PKG::STREAM_ID_WIDTH-1:0]           resp_stream_id_o,
  output logic                                          resp_err_o
);

  localparam int unsigned OpW  = $bits(VPU_PKG::vpu_exec_req_t);
  localparam int unsigned SidW = VPU_PKG::STREAM_ID_WIDTH;
  localparam int unsigned LatW = $clog2(RD_LAT + 1);
  localparam int unsigned WdW  = $clog2(EXEC_TIMEOUT + 1);

  typedef enum logic [2:0] {
    StIdle, StLatch, StRead, StRwait, StExec, StEwait, StWrite, StResp
  } state_e;

  state_e                      r_state;
  logic [OpW-1:0]              r_op;
  logic [2:0]                  r_rvalid;
  logic [2:0]                  r_rd_en;
  logic [ADDR_WIDTH-1:0]       r_rd_addr0, r_rd_addr1, r_rd_addr2, r_waddr;
  logic [SidW-1:0]             r_sid;
  logic [LatW-1:0]             r_lat;
  logic [DATA_WIDTH-1:0]       r_src0, r_src1, r_src2, r_wr_data;
  logic                        r_exec_valid;
  logic [WdW-1:0]              r_wdog;
  logic                        r_wr_en;
  logic                        r_resp_valid;
  logic                        r_err;

  VPU_PKG::vpu_instr_decoded_t w_instr;
  logic                        w_wd_expire;

  assign w_instr = VPU_PKG::vpu_instr_decoded_t'(instr_decoded_i);
  // Expiry is judged on the post-increment count so EWAIT lasts exactly EXEC_TIMEOUT cycles.
  assign w_wd_expire = (r_wdog >= WdW'(EXEC_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= StIdle;
      r_op         <= '0;
      r_rvalid     <= '0;
      r_rd_en      <= '0;
      r_rd_addr0   <= '0;
      r_rd_addr1   <= '0;
      r_rd_addr2   <= '0;
      r_waddr      <= '0;
      r_sid        <= '0;
      r_lat        <= '0;
      r_src0       <= '0;
      r_src1       <= '0;
      r_src2       <= '0;
      r_wr_data    <= '0;
      r_exec_valid <= 1'b0;
      r_wdog       <= '0;
      r_wr_en      <= 1'b0;
      r_resp_valid <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_rd_en <= '0;
      r_wr_en <= 1'b0;
      unique case (r_state)
        StIdle: if (ctrl_valid_i) r_state <= StLatch;
        StLatch: begin
          // Decoder output is registered, so the instruction is sampled one cycle after handshake.
          r_op       <= w_instr.op_func;
          r_rvalid   <= w_instr.rvalid;
          r_rd_addr0 <= ADDR_WIDTH'(w_instr.raddr0);
          r_rd_addr1 <= ADDR_WIDTH'(w_instr.raddr1);
          r_rd_addr2 <= ADDR_WIDTH'(w_instr.raddr2);
          r_waddr    <= ADDR_WIDTH'(w_instr.waddr);
          r_sid      <= stream_id_i;
          if (w_instr.op_func == '0) begin
            r_err        <= 1'b1;
            r_resp_valid <= 1'b1;
            r_state      <= StResp;
          end else begin
            r_rd_en <= w_instr.rvalid;
            r_state <= StRead;
          end
        end
        StRead: begin
          r_lat   <= LatW'(RD_LAT - 1);
          r_state <= StRwait;
        end
        StRwait: begin
          if (r_lat == '0) begin
            r_src0       <= r_rvalid[0] ? rd_data0_i : '0;
            r_src1       <= r_rvalid[1] ? rd_data1_i : '0;
            r_src2       <= r_rvalid[2] ? rd_data2_i : '0;
            r_exec_valid <= 1'b1;
            r_state      <= StExec;
          end else begin
            r_lat <= r_lat - LatW'(1);
          end
        end
        StExec: begin
          if (exec_ready_i) begin
            r_exec_valid <= 1'b0;
            r_wdog       <= '0;
            r_state      <= StEwait;
          end
        end
        StEwait: begin
          // A done pulse beats a simultaneous watchdog expiry.
          if (exec_done_i) begin
            r_wr_data <= exec_result_i;
            r_wr_en   <= 1'b1;
            r_state   <= StWrite;
          end else begin
            if (r_wdog != WdW'(EXEC_TIMEOUT)) r_wdog <= r_wdog + WdW'(1);
            if (w_wd_expire) begin
              r_err        <= 1'b1;
              r_resp_valid <= 1'b1;
              r_state      <= StResp;
            end
          end
        end
        StWrite: begin
          r_resp_valid <= 1'b1;
          r_state      <= StResp;
        end
        StResp: begin
          if (resp_ready_i) begin
            r_resp_valid <= 1'b0;
            r_err        <= 1'b0;
            r_state      <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign ctrl_ready_o     = (r_state == StIdle);
  assign rd_en_o          = r_rd_en;
  assign rd_addr0_o       = r_rd_addr0;
  assign rd_addr1_o       = r_rd_addr1;
  assign rd_addr2_o       = r_rd_addr2;
  assign exec_valid_o     = r_exec_valid;
  assign exec_op_o        = r_op;
  assign exec_src0_o      = r_src0;
  assign exec_src1_o      = r_src1;
  assign exec_src2_o      = r_src2;
  assign wr_en_o          = r_wr_en;
  assign wr_addr_o        = r_waddr;
  assign wr_data_o        = r_wr_data;
  assign resp_valid_o     = r_resp_valid;
  assign resp_stream_id_o = r_sid;
  assign resp_err_o       = r_err;

endmodule

// File: tb/tb_vpu_issue_ctrl.sv
// Directed bench for vpu_issue_ctrl: register-file latency model, exec/resp handshakes,
// invalid opcode, watchdog expiry and mid-flight reset.

module tb_vpu_issue_ctrl;
  localparam int unsigned DW = 64;
  localparam int unsigned AW = 8;
  localparam int unsigned RL = 3;
  localparam int unsigned TO = 15;
  localparam int unsigned IW = $bits(VPU_PKG::vpu_instr_decoded_t);
  localparam int unsigned SW = VPU_PKG::STREAM_ID_WIDTH;
  localparam int unsigned OW = $bits(VPU_PKG::vpu_exec_req_t);
  localparam logic [DW-1:0] JUNK = 64'hDEAD_BEEF_0BAD_F00D;

  logic          clk;
  logic          rst_n;
  logic          ctrl_valid_i;
  logic          ctrl_ready_o;
  logic [IW-1:0] instr_decoded_i;
  logic [SW-1:0] stream_id_i;
  logic [2:0]    rd_en_o;
  logic [AW-1:0] rd_addr0_o, rd_addr1_o, rd_addr2_o;
  logic [DW-1:0] rd_data0_i, rd_data1_i, rd_data2_i;
  logic          exec_valid_o;
  logic          exec_ready_i;
  logic [OW-1:0] exec_op_o;
  logic [DW-1:0] exec_src0_o, exec_src1_o, exec_src2_o;
  logic          exec_done_i;
  logic [DW-1:0] exec_result_i;
  logic          wr_en_o;
  logic [AW-1:0] wr_addr_o;
  logic [DW-1:0] wr_data_o;
  logic          resp_valid_o;
  logic          resp_ready_i;
  logic [SW-1:0] resp_stream_id_o;
  logic          resp_err_o;

  vpu_issue_ctrl #(
    .DATA_WIDTH  (DW),
    .ADDR_WIDTH  (AW),
    .RD_LAT      (RL),
    .EXEC_TIMEOUT(TO)
  ) u_dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .ctrl_valid_i    (ctrl_valid_i),
    .ctrl_ready_o    (ctrl_ready_o),
    .instr_decoded_i (instr_decoded_i),
    .stream_id_i     (stream_id_i),
    .rd_en_o         (rd_en_o),
    .rd_addr0_o      (rd_addr0_o),
    .rd_addr1_o      (rd_addr1_o),
    .rd_addr2_o      (rd_addr2_o),
    .rd_data0_i      (rd_data0_i),
    .rd_data1_i      (rd_data1_i),
    .rd_data2_i      (rd_data2_i),
    .exec_valid_o    (exec_valid_o),
    .exec_ready_i    (exec_ready_i),
    .exec_op_o       (exec_op_o),
    .exec_src0_o     (exec_src0_o),
    .exec_src1_o     (exec_src1_o),
    .exec_src2_o     (exec_src2_o),
    .exec_done_i     (exec_done_i),
    .exec_result_i   (exec_result_i),
    .wr_en_o         (wr_en_o),
    .wr_addr_o       (wr_addr_o),
    .wr_data_o       (wr_data_o),
    .resp_valid_o    (resp_valid_o),
    .resp_ready_i    (resp_ready_i),
    .resp_stream_id_o(resp_stream_id_o),
    .resp_err_o      (resp_err_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rf_val(input logic [AW-1:0] a);
    return {a, 24'h5A5A5A, a, 24'hC3C3C3};
  endfunction

  // Register file: data is only meaningful exactly RL cycles after the strobe, junk otherwise.
  logic [2:0]    pen [RL];
  logic [AW-1:0] pa0 [RL];
  logic [AW-1:0] pa1 [RL];
  logic [AW-1:0] pa2 [RL];

  always @(posedge clk) begin
    pen[0] <= rd_en_o;
    pa0[0] <= rd_addr0_o;
    pa1[0] <= rd_addr1_o;
    pa2[0] <= rd_addr2_o;
    for (int i = 1; i < RL; i++) begin
      pen[i] <= pen[i-1];
      pa0[i] <= pa0[i-1];
      pa1[i] <= pa1[i-1];
      pa2[i] <= pa2[i-1];
    end
  end

  assign rd_data0_i = pen[RL-1][0] ? rf_val(pa0[RL-1]) : JUNK;
  assign rd_data1_i = pen[RL-1][1] ? rf_val(pa1[RL-1]) : JUNK;
  assign rd_data2_i = pen[RL-1][2] ? rf_val(pa2[RL-1]) : JUNK;

  int n_rd0 = 0, n_rd1 = 0, n_rd2 = 0, n_ex = 0, n_wr = 0;
  always @(posedge clk) begin
    if (rd_en_o[0]) n_rd0 <= n_rd0 + 1;
    if (rd_en_o[1]) n_rd1 <= n_rd1 + 1;
    if (rd_en_o[2]) n_rd2 <= n_rd2 + 1;
    if (exec_valid_o) n_ex <= n_ex + 1;
    if (wr_en_o) n_wr <= n_wr + 1;
  end

  int n_chk = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // done_dly < 0 means the execution unit never answers.
  task automatic do_instr(input logic [5:0] op, input logic [2:0] rv, input logic [7:0] a0,
                          input logic [7:0] a1, input logic [7:0] a2, input logic [7:0] wa,
                          input logic [SW-1:0] sid, input int rdy_dly, input int done_dly,
                          input int resp_dly, input logic [DW-1:0] res);
    VPU_PKG::vpu_instr_decoded_t ins;
    int c0, b0, b1, b2, bex, bwr;
    logic e_err;
    logic [DW-1:0] e0, e1, e2;
    e0 = rv[0] ? rf_val(a0) : '0;
    e1 = rv[1] ? rf_val(a1) : '0;
    e2 = rv[2] ? rf_val(a2) : '0;
    ins.op_func = op;
    ins.rvalid  = rv;
    ins.raddr0  = a0;
    ins.raddr1  = a1;
    ins.raddr2  = a2;
    ins.waddr   = wa;
    b0 = n_rd0; b1 = n_rd1; b2 = n_rd2; bex = n_ex; bwr = n_wr;
    chk_eq("idle_ready", ctrl_ready_o, 1);
    c0 = cyc;
    ctrl_valid_i = 1'b1;
    tick;
    ctrl_valid_i    = 1'b0;
    instr_decoded_i = ins;
    stream_id_i     = sid;
    chk_eq("latch_ready", ctrl_ready_o, 0);
    tick;
    instr_decoded_i = '0;
    stream_id_i     = '0;
    chk_eq("rd_en", rd_en_o, rv);
    chk_eq("rd_addr0", rd_addr0_o, a0);
    chk_eq("rd_addr1", rd_addr1_o, a1);
    chk_eq("rd_addr2", rd_addr2_o, a2);
    exec_ready_i = (rdy_dly == 0);
    for (int i = 0; i < RL; i++) begin
      tick;
      chk_eq("rwait_exec_valid", exec_valid_o, 0);
    end
    tick;
    chk_eq("exec_valid", exec_valid_o, 1);
    chk_eq("exec_op", exec_op_o, op);
    chk_eq("exec_src0", exec_src0_o, e0);
    chk_eq("exec_src1", exec_src1_o, e1);
    chk_eq("exec_src2", exec_src2_o, e2);
    for (int i = 0; i < rdy_dly; i++) begin
      exec_done_i   = (i == 0);  // stray done while still in EXEC must be ignored
      exec_result_i = JUNK;
      tick;
      exec_done_i = 1'b0;
      chk_eq("exec_hold_valid", exec_valid_o, 1);
      chk_eq("exec_hold_src0", exec_src0_o, e0);
    end
    exec_ready_i = 1'b1;
    tick;
    exec_ready_i = 1'b0;
    chk_eq("ewait_exec_valid", exec_valid_o, 0);
    if (done_dly >= 0) begin
      for (int i = 0; i < done_dly; i++) tick;
      exec_done_i   = 1'b1;
      exec_result_i = res;
      tick;
      exec_done_i   = 1'b0;
      exec_result_i = JUNK;
      chk_eq("wr_en", wr_en_o, 1);
      chk_eq("wr_addr", wr_addr_o, wa);
      chk_eq("wr_data", wr_data_o, res);
      tick;
      e_err = 1'b0;
    end else begin
      for (int i = 0; i < int'(TO) - 1; i++) begin
        tick;
        chk_eq("ewait_resp_valid", resp_valid_o, 0);
      end
      tick;
      e_err = 1'b1;
    end
    chk_eq("resp_valid", resp_valid_o, 1);
    chk_eq("resp_id", resp_stream_id_o, sid);
    chk_eq("resp_err", resp_err_o, e_err);
    chk_eq("resp_wr_en", wr_en_o, 0);
    resp_ready_i = (resp_dly == 0);
    ctrl_valid_i = (resp_dly > 0);
    for (int i = 0; i < resp_dly; i++) begin
      tick;
      chk_eq("hold_resp_valid", resp_valid_o, 1);
      chk_eq("hold_resp_id", resp_stream_id_o, sid);
      chk_eq("hold_resp_err", resp_err_o, e_err);
      chk_eq("hold_ctrl_ready", ctrl_ready_o, 0);
    end
    resp_ready_i = 1'b1;
    tick;
    resp_ready_i = 1'b0;
    chk_eq("done_ctrl_ready", ctrl_ready_o, 1);
    chk_eq("done_resp_valid", resp_valid_o, 0);
    chk_eq("done_resp_err", resp_err_o, 0);
    if (done_dly >= 0)
      chk_eq("latency", cyc - c0, RL + 7 + rdy_dly + done_dly + resp_dly);
    chk_eq("n_rd0", n_rd0 - b0, rv[0]);
    chk_eq("n_rd1", n_rd1 - b1, rv[1]);
    chk_eq("n_rd2", n_rd2 - b2, rv[2]);
    chk_eq("n_exec_valid", n_ex - bex, rdy_dly + 1);
    chk_eq("n_wr", n_wr - bwr, e_err ? 0 : 1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    VPU_PKG::vpu_instr_decoded_t ins;
    int c0, b0, b1, b2, bex, bwr;
    rst_n           = 1'b0;
    ctrl_valid_i    = 1'b0;
    instr_decoded_i = '0;
    stream_id_i     = '0;
    exec_ready_i    = 1'b0;
    exec_done_i     = 1'b0;
    exec_result_i   = JUNK;
    resp_ready_i    = 1'b0;
    repeat (3) tick;
    chk_eq("rst_ctrl_ready", ctrl_ready_o, 1);
    chk_eq("rst_rd_en", rd_en_o, 0);
    chk_eq("rst_exec_valid", exec_valid_o, 0);
    chk_eq("rst_wr_en", wr_en_o, 0);
    chk_eq("rst_resp_valid", resp_valid_o, 0);
    chk_eq("rst_resp_err", resp_err_o, 0);
    chk_eq("rst_resp_id", resp_stream_id_o, 0);
    chk_eq("rst_wr_data", wr_data_o, 0);
    rst_n = 1'b1;
    tick;

    // FADD: two operands, everything immediate
    do_instr(6'd1, 3'b011, 8'd3, 8'd4, 8'd7, 8'd9, 4'd5, 0, 0, 0, 64'h1111_2222_3333_4444);
    // FADD3: three operands, exec held off for 4 cycles, done 2 cycles later
    do_instr(6'd2, 3'b111, 8'd10, 8'd11, 8'd12, 8'd20, 4'd7, 4, 2, 0, 64'hCAFE_0000_1234_5678);
    // Exec never completes
    do_instr(6'd3, 3'b001, 8'd1, 8'd2, 8'd3, 8'd30, 4'd9, 0, -1, 0, 64'h0);
    // Done lands on the expiry cycle
    do_instr(6'd3, 3'b100, 8'd5, 8'd6, 8'd40, 8'd31, 4'd10, 0, int'(TO) - 1, 0,
             64'h0F0F_F0F0_AAAA_5555);
    // Response back-pressure with a waiting request, then the next one follows
    do_instr(6'd4, 3'b010, 8'd8, 8'd50, 8'd9, 8'd12, 4'd3, 0, 0, 10, 64'h7777_8888_9999_AAAA);
    do_instr(6'd5, 3'b101, 8'd60, 8'd61, 8'd62, 8'd63, 4'd4, 1, 0, 0, 64'h0123_4567_89AB_CDEF);

    // Invalid opcode
    b0 = n_rd0; b1 = n_rd1; b2 = n_rd2; bex = n_ex; bwr = n_wr;
    ins.op_func = '0;
    ins.rvalid  = 3'b111;
    ins.raddr0  = 8'd1;
    ins.raddr1  = 8'd2;
    ins.raddr2  = 8'd3;
    ins.waddr   = 8'd4;
    c0 = cyc;
    ctrl_valid_i = 1'b1;
    tick;
    ctrl_valid_i    = 1'b0;
    instr_decoded_i = ins;
    stream_id_i     = 4'd2;
    tick;
    instr_decoded_i = '0;
    stream_id_i     = '0;
    chk_eq("inv_resp_valid", resp_valid_o, 1);
    chk_eq("inv_resp_err", resp_err_o, 1);
    chk_eq("inv_resp_id", resp_stream_id_o, 2);
    chk_eq("inv_latency", cyc - c0, 2);
    chk_eq("inv_rd_en", rd_en_o, 0);
    resp_ready_i = 1'b1;
    tick;
    resp_ready_i = 1'b0;
    chk_eq("inv_ctrl_ready", ctrl_ready_o, 1);
    chk_eq("inv_resp_err_clr", resp_err_o, 0);
    chk_eq("inv_n_rd", (n_rd0 - b0) + (n_rd1 - b1) + (n_rd2 - b2), 0);
    chk_eq("inv_n_exec", n_ex - bex, 0);
    chk_eq("inv_n_wr", n_wr - bwr, 0);

    // Reset while waiting for the execution unit
    ins.op_func = 6'd1;
    ins.rvalid  = 3'b011;
    ins.raddr0  = 8'd21;
    ins.raddr1  = 8'd22;
    ins.raddr2  = 8'd23;
    ins.waddr   = 8'd24;
    ctrl_valid_i = 1'b1;
    tick;
    ctrl_valid_i    = 1'b0;
    instr_decoded_i = ins;
    stream_id_i     = 4'd6;
    tick;
    instr_decoded_i = '0;
    stream_id_i     = '0;
    repeat (RL + 1) tick;
    chk_eq("rstx_exec_valid", exec_valid_o, 1);
    exec_ready_i = 1'b1;
    tick;
    exec_ready_i = 1'b0;
    tick;
    bwr   = n_wr;
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    chk_eq("rstx_ctrl_ready", ctrl_ready_o, 1);
    chk_eq("rstx_exec_valid0", exec_valid_o, 0);
    chk_eq("rstx_exec_op", exec_op_o, 0);
    chk_eq("rstx_src0", exec_src0_o, 0);
    chk_eq("rstx_rd_addr0", rd_addr0_o, 0);
    chk_eq("rstx_wr_addr", wr_addr_o, 0);
    chk_eq("rstx_resp_valid", resp_valid_o, 0);
    chk_eq("rstx_resp_id", resp_stream_id_o, 0);
    exec_done_i   = 1'b1;
    exec_result_i = 64'h5555_6666_7777_8888;
    tick;
    exec_done_i   = 1'b0;
    exec_result_i = JUNK;
    tick;
    chk_eq("rstx_wr_en", wr_en_o, 0);
    chk_eq("rstx_n_wr", n_wr - bwr, 0);
    chk_eq("rstx_idle", ctrl_ready_o, 1);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/vpu_issue_ctrl.md
# vpu_issue_ctrl

Issue controller directly downstream of the VPU instruction decoder. Accepts one decoded instruction per handshake, then:
- reads up to three source operands from the vector register file;
- launches the FP/reduction execution unit and waits for its result;
- writes the result to the destination address;
- returns a completion response tagged with the original stream ID.

It processes one instruction at a time (non-pipelined) and is the sole driver of the decoder's `ctrl_ready_i`.

## Interface
Parameters:
- `DATA_WIDTH`, 512: vector operand/result width in bits.
- `ADDR_WIDTH`, 8: register-file address width; matches the raddr/waddr fields of `VPU_PKG::vpu_instr_decoded_t`.
- `RD_LAT`, 2: fixed register-file read latency in cycles, ≥1.
- `EXEC_TIMEOUT`, 1023: maximum cycles spent in WAIT_EXEC before an error response.

Ports (one clock `clk`; reset `rst_n` is synchronous and active-low):
- `clk`  in  1  clock.
- `rst_n`  in  1  synchronous active-low reset.
- `ctrl_valid_i`  in  1  decoder has a request this cycle.
- `ctrl_ready_o`  out  1  controller accepts a request; equals (state==IDLE).
- `instr_decoded_i`  in  `$bits(VPU_PKG::vpu_instr_decoded_t)`  decoded instruction, valid the cycle after acceptance.
- `stream_id_i`  in  `VPU_PKG::STREAM_ID_WIDTH`  stream tag, valid the cycle after acceptance.
- `rd_en_o`  out  3  per-port read strobe, one-cycle pulse.
- `rd_addr0_o`, `rd_addr1_o`, `rd_addr2_o`  out  `ADDR_WIDTH`  read addresses.
- `rd_data0_i`, `rd_data1_i`, `rd_data2_i`  in  `DATA_WIDTH`  read data, valid `RD_LAT` cycles after `rd_en_o`.
- `exec_valid_o`  out  1  execution request.
- `exec_ready_i`  in  1  execution unit accepts the request.
- `exec_op_o`  out  `$bits(VPU_PKG::vpu_exec_req_t)`  `op_func` forwarded unchanged.
- `exec_src0_o`, `exec_src1_o`, `exec_src2_o`  out  `DATA_WIDTH`  captured operands.
- `exec_done_i`  in  1  result valid, single-cycle pulse.
- `exec_result_i`  in  `DATA_WIDTH`  result.
- `wr_en_o`  out  1  write strobe.
- `wr_addr_o`  out  `ADDR_WIDTH`  write address.
- `wr_data_o`  out  `DATA_WIDTH`  write data.
- `resp_valid_o`  out  1  completion response valid.
- `resp_ready_i`  in  1  response consumer ready.
- `resp_stream_id_o`  out  `VPU_PKG::STREAM_ID_WIDTH`  tag of the completed instruction.
- `resp_err_o`  out  1  1 = invalid opcode or exec timeout.

## Operation
- FSM states: IDLE, LATCH, READ, RWAIT, EXEC, EWAIT, WRITE, RESP.
- **IDLE**
  - `ctrl_ready_o`=1.
  - On `ctrl_valid_i`=1, go to LATCH.
- **LATCH**
  - Register `instr_decoded_i` and `stream_id_i`. The decoder's output is registered, so it is valid only one cycle after the handshake.
  - If the captured `op_func` is all zero (invalid opcode): set err, go to RESP.
  - Otherwise go to READ.
- **READ** (one cycle)
  - `rd_en_o` = captured `rvalid`.
  - `rd_addrN_o` = captured `raddrN`.
  - Load the latency counter with `RD_LAT`-1, go to RWAIT.
- **RWAIT**
  - Count down; when the counter reaches 0, the `rd_dataN_i` inputs are sampled on the next edge.
  - Sample only ports whose `rvalid` bit is set; unselected operand registers are cleared to 0.
  - Go to EXEC.
- **EXEC**
  - Hold `exec_valid_o`=1 with `exec_op_o` and `exec_srcN_o` stable.
  - On `exec_ready_i`: clear the watchdog, go to EWAIT.
- **EWAIT**
  - On `exec_done_i`: capture `exec_result_i`, go to WRITE.
  - Otherwise increment the watchdog. When the watchdog equals `EXEC_TIMEOUT`: set err, go to RESP with no write.
- **WRITE** (one cycle)
  - `wr_en_o`=1, `wr_addr_o`=captured `waddr`, `wr_data_o`=captured result.
  - Go to RESP.
- **RESP**
  - Hold `resp_valid_o`=1 with stable `resp_stream_id_o` and `resp_err_o`.
  - On `resp_ready_i`: return to IDLE and clear err.
- Boundary conditions:
  - `exec_done_i` outside EWAIT is ignored.
  - An `exec_done_i` arriving in the same cycle the watchdog expires wins: go to WRITE, err=0.
- Reset applies in any state and abandons any in-flight instruction.

## Timing
- Reset values:
  - `ctrl_ready_o`=1 (FSM resets to IDLE).
  - All other outputs 0, including `rd_en_o`, `exec_valid_o`, `wr_en_o`, `resp_valid_o`, `resp_err_o`, and all address/data/id outputs.
- Handshake rules:
  - Handshake at edge T0.
  - LATCH in cycle T1, READ in T2, data sampled at the end of cycle T2+`RD_LAT`.
  - EXEC asserted from T3+`RD_LAT`.
  - With exec ready immediately and done the cycle after, plus immediate resp ready: minimum T0-to-IDLE is `RD_LAT`+7 cycles.
- `ctrl_ready_o` is low from T1 until the cycle after the RESP handshake, so there is no back-to-back acceptance.
- Invalid opcode: `resp_valid_o` asserts in T2 with err=1 and no register-file or exec traffic.
- All outputs are registered or decoded from state; there are no combinational paths from inputs to outputs except none.
- Watchdog width: `$clog2(EXEC_TIMEOUT+1)`. It saturates and never wraps.

## Test plan
- FADD (`rvalid`=011, raddr0=3, raddr1=4, waddr=9, stream 5) with exec ready/done immediate → `rd_en_o`=011 with addrs 3/4; `exec_srcN_o` = src0/src1, src2=0; `wr_en_o` one cycle, addr 9 = result; `resp_valid_o` with id 5, err=0; back in IDLE `RD_LAT`+7 cycles after the handshake.
- FADD3 (`rvalid`=111), `RD_LAT`=3 → all three strobes pulse once; operands sampled exactly 3 cycles after READ; `exec_valid_o` held for 4 cycles while `exec_ready_i`=0.
- Invalid opcode (`op_func`=0), stream 2 → no `rd_en_o`/`exec_valid_o`/`wr_en_o`; response with err=1, id 2, asserted two cycles after the handshake.
- Exec never completes, `EXEC_TIMEOUT`=15 → `wr_en_o` stays 0; resp err=1 after 15 EWAIT cycles. Repeat with `exec_done_i` on the expiry cycle → normal write, err=0.
- `resp_ready_i` held low 10 cycles while `ctrl_valid_i`=1 → `ctrl_ready_o`=0 and response fields stable throughout; the next instruction is accepted the cycle after resp ready.
- `rst_n` low during EWAIT → next cycle in IDLE with all outputs at reset values; a late `exec_done_i` causes no write.
